multi_fifo: RTL and testbench

Parametrised multi-channel synchronous FIFO: the next generation of the two-channel UDB datapath FIFO pair, with configurable data width, depth and channel count. It adds per-channel fill levels, a threshold-based DMA request and sticky overflow/underflow flags. It sits between bus-side DMA/CPU writers and UDB-side consumers in the DMA test design; all channels share one clock domain.

---
 rtl/multi_fifo.sv | 101 ++++++++++
 tb/tb_multi_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_fifo.sv
// multi_fifo: a set of independent synchronous FIFO channels sharing one clock.
// Each channel has first-word fall-through read data, a fill level, a
// threshold DMA request and sticky overflow/underflow error flags.
module multi_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CHANNELS   = 2,
    parameter int REQ_LEVEL  = 2,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [CHANNELS-1:0]            wr_en,
    input  logic [CHANNELS*DATA_WIDTH-1:0] wr_data,
    input  logic [CHANNELS-1:0]            rd_en,
    output logic [CHANNELS*DATA_WIDTH-1:0] rd_data,
    output logic [CHANNELS-1:0]            not_full,
    output logic [CHANNELS-1:0]            empty,
    output logic [CHANNELS*LW-1:0]         level,
    output logic [CHANNELS-1:0]            dma_req,
    output logic [CHANNELS-1:0]            overflow,
    output logic [CHANNELS-1:0]            underflow,
    input  logic [CHANNELS-1:0]            err_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] REQ_LVL  = LW'(REQ_LEVEL);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]         wptr;
        logic [PW-1:0]         rptr;
        logic [LW-1:0]         cnt;
        logic                  is_full;
        logic                  is_empty;
        logic                  push_ok;
        logic                  pop_ok;

        // Acceptance is decided only from the registered level, so a full
        // channel rejects a push even when a pop frees a slot in the same cycle.
        assign is_full  = (cnt == FULL_LVL);
        assign is_empty = (cnt == '0);
        assign push_ok  = wr_en[c] && !is_full;
        assign pop_ok   = rd_en[c] && !is_empty;

        // Storage is deliberately left out of reset; empty masks stale entries.
        always_ff @(posedge clock) begin
            if (push_ok) begin
                mem[wptr] <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Pointers and level track accepted operations; pointers wrap at DEPTH.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (push_ok) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop_ok) begin
                    rptr <= rptr + 1'b1;
                end
                case ({push_ok, pop_ok})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        // Sticky error flags; a new error wins over a clear in the same cycle.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                overflow[c]  <= 1'b0;
                underflow[c] <= 1'b0;
            end else begin
                if (wr_en[c] && is_full) begin
                    overflow[c] <= 1'b1;
                end else if (err_clr[c]) begin
                    overflow[c] <= 1'b0;
                end
                if (rd_en[c] && is_empty) begin
                    underflow[c] <= 1'b1;
                end else if (err_clr[c]) begin
                    underflow[c] <= 1'b0;
                end
            end
        end

        assign rd_data[c*DATA_WIDTH +: DATA_WIDTH] = is_empty ? '0 : mem[rptr];
        assign level[c*LW +: LW] = cnt;
        assign not_full[c]       = !is_full;
        assign empty[c]          = is_empty;
        assign dma_req[c]        = (cnt >= REQ_LVL);
    end

endmodule

// File: tb/tb_multi_fifo.sv
// Directed testbench for multi_fifo with default parameters (two channels,
// four entries of eight bits, DMA request at level two).
module tb_multi_fifo;

    logic        clock;
    logic        reset_n;
    logic [1:0]  wr_en;
    logic [15:0] wr_data;
    logic [1:0]  rd_en;
    logic [15:0] rd_data;
    logic [1:0]  not_full;
    logic [1:0]  empty;
    logic [5:0]  level;
    logic [1:0]  dma_req;
    logic [1:0]  overflow;
    logic [1:0]  underflow;
    logic [1:0]  err_clr;

    int vectors;
    int misses;

    multi_fifo dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .not_full  (not_full),
        .empty     (empty),
        .level     (level),
        .dma_req   (dma_req),
        .overflow  (overflow),
        .underflow (underflow),
        .err_clr   (err_clr)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            misses++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests, let the edge happen, then idle the inputs.
    task automatic applyStimulus(input logic [1:0] wr, input logic [7:0] d0,
                                 input logic [7:0] d1, input logic [1:0] rd,
                                 input logic [1:0] clr);
        wr_en   = wr;
        wr_data = {d1, d0};
        rd_en   = rd;
        err_clr = clr;
        @(posedge clock);
        #1;
        wr_en   = '0;
        wr_data = '0;
        rd_en   = '0;
        err_clr = '0;
    endtask

    initial begin
        vectors = 0;
        misses  = 0;
        reset_n = 1'b0;
        wr_en   = '0;
        wr_data = '0;
        rd_en   = '0;
        err_clr = '0;
        #1;
        checkOutput("rst_empty", empty, 2'b11);
        checkOutput("rst_not_full", not_full, 2'b11);
        checkOutput("rst_level", level, 6'd0);
        checkOutput("rst_dma", dma_req, 2'b00);
        checkOutput("rst_flags", {overflow, underflow}, 4'b0000);
        checkOutput("rst_rd_data", rd_data, 16'h0000);
        #11;
        reset_n = 1'b1;

        // Fill channel 0
        applyStimulus(2'b01, 8'hFF, 8'h00, 2'b00, 2'b00);
        checkOutput("fill1_level", level[2:0], 3'd1);
        checkOutput("fill1_head", rd_data[7:0], 8'hFF);
        checkOutput("fill1_empty", empty[0], 1'b0);
        checkOutput("fill1_dma", dma_req[0], 1'b0);
        applyStimulus(2'b01, 8'h88, 8'h00, 2'b00, 2'b00);
        checkOutput("fill2_level", level[2:0], 3'd2);
        checkOutput("fill2_dma", dma_req[0], 1'b1);
        applyStimulus(2'b01, 8'h44, 8'h00, 2'b00, 2'b00);
        checkOutput("fill3_level", level[2:0], 3'd3);
        checkOutput("fill3_not_full", not_full[0], 1'b1);
        applyStimulus(2'b01, 8'h11, 8'h00, 2'b00, 2'b00);
        checkOutput("fill4_level", level[2:0], 3'd4);
        checkOutput("fill4_not_full", not_full[0], 1'b0);
        checkOutput("ch1_empty", empty[1], 1'b1);
        checkOutput("ch1_level", level[5:3], 3'd0);

        // Overflow on a full channel, then clear
        applyStimulus(2'b01, 8'hAA, 8'h00, 2'b00, 2'b00);
        checkOutput("ovf_level", level[2:0], 3'd4);
        checkOutput("ovf_flag", overflow, 2'b01);
        checkOutput("ovf_head", rd_data[7:0], 8'hFF);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 2'b01);
        checkOutput("ovf_clear", overflow, 2'b00);

        // Drain channel 0 in order
        checkOutput("pop1_head", rd_data[7:0], 8'hFF);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 2'b00);
        checkOutput("pop1_not_full", not_full[0], 1'b1);
        checkOutput("pop2_head", rd_data[7:0], 8'h88);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 2'b00);
        checkOutput("pop3_head", rd_data[7:0], 8'h44);
        checkOutput("pop3_dma", dma_req[0], 1'b1);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 2'b00);
        checkOutput("pop3_dma_off", dma_req[0], 1'b0);
        checkOutput("pop4_head", rd_data[7:0], 8'h11);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 2'b00);
        checkOutput("drain_empty", empty[0], 1'b1);
        checkOutput("drain_rd_data", rd_data[7:0], 8'h00);
        checkOutput("drain_underflow", underflow[0], 1'b0);

        // Push and pop together on empty channel 1
        applyStimulus(2'b10, 8'h00, 8'h5A, 2'b10, 2'b00);
        checkOutput("udf_level", level[5:3], 3'd1);
        checkOutput("udf_head", rd_data[15:8], 8'h5A);
        checkOutput("udf_flag", underflow, 2'b10);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b10, 2'b00);
        checkOutput("udf_pop_level", level[5:3], 3'd0);
        checkOutput("udf_held", underflow[1], 1'b1);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b10, 2'b10);
        checkOutput("udf_set_beats_clr", underflow[1], 1'b1);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 2'b10);
        checkOutput("udf_clear", underflow[1], 1'b0);

        // Full channel 0 with push and pop in the same cycle
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(2'b01, 8'(i), 8'h00, 2'b00, 2'b00);
        end
        checkOutput("pp_full_level", level[2:0], 3'd4);
        applyStimulus(2'b01, 8'h09, 8'h00, 2'b01, 2'b00);
        checkOutput("pp_level", level[2:0], 3'd3);
        checkOutput("pp_head", rd_data[7:0], 8'h02);
        checkOutput("pp_overflow", overflow[0], 1'b1);
        for (int i = 2; i <= 4; i++) begin
            checkOutput("pp_drain_head", rd_data[7:0], 32'(i));
            applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 2'b00);
        end
        checkOutput("pp_drain_empty", empty[0], 1'b1);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 2'b01);
        checkOutput("pp_clear", overflow[0], 1'b0);

        // Steady-state push and pop through pointer wrap at level 2
        applyStimulus(2'b01, 8'h20, 8'h00, 2'b00, 2'b00);
        applyStimulus(2'b01, 8'h21, 8'h00, 2'b00, 2'b00);
        for (int i = 0; i < 10; i++) begin
            checkOutput("wrap_head", rd_data[7:0], 32'h20 + i);
            applyStimulus(2'b01, 8'(8'h22 + i), 8'h00, 2'b01, 2'b00);
            checkOutput("wrap_level", level[2:0], 3'd2);
            checkOutput("wrap_flags", {overflow, underflow}, 4'b0000);
        end
        checkOutput("wrap_tail1", rd_data[7:0], 8'h2A);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 2'b00);
        checkOutput("wrap_tail2", rd_data[7:0], 8'h2B);
        applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 2'b00);
        checkOutput("wrap_empty", empty[0], 1'b1);

        // Asynchronous reset in the middle of traffic
        applyStimulus(2'b01, 8'h71, 8'h00, 2'b00, 2'b00);
        applyStimulus(2'b01, 8'h72, 8'h00, 2'b00, 2'b00);
        applyStimulus(2'b01, 8'h73, 8'h00, 2'b00, 2'b00);
        checkOutput("mid_level", level[2:0], 3'd3);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_level", level, 6'd0);
        checkOutput("mid_rst_empty", empty, 2'b11);
        checkOutput("mid_rst_dma", dma_req, 2'b00);
        checkOutput("mid_rst_rd_data", rd_data, 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(2'b01, 8'h33, 8'h00, 2'b00, 2'b00);
        checkOutput("post_rst_head", rd_data[7:0], 8'h33);
        checkOutput("post_rst_level", level[2:0], 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("[TB] FAIL timeout: observed no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
